// File: rtl/lut_demux_pkg.sv
// Purpose     : shared types and constants for the key-lookup demux/mux pair.
// Latency     : n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: channel/key/data widths, routing-table entry struct, identity
// reset table, saturating-increment helper for the drop counter.
package lut_demux_pkg;

    localparam int NR_CH    = 4;
    localparam int KEY_LEN  = 2;
    localparam int DATA_LEN = 2;
    localparam int IDX_W    = 2;   // log2(NR_CH)
    localparam int CNT_W    = 8;   // drop counter width

    // One routing-table entry: an item whose key equals 'key' may be
    // steered to this entry's channel only while 'en' is set.
    typedef struct packed {
        logic [KEY_LEN-1:0] key;
        logic               en;
    } entry_t;

    // Packed so the whole table can be passed through a single port.
    // Element i is the entry for output channel i.
    typedef entry_t [NR_CH-1:0] table_t;

    // Identity map: entry i = {key=i, en=1}. Laid out MSB-first, entry 3 first.
    localparam table_t TABLE_RST = {
        entry_t'({2'd3, 1'b1}),
        entry_t'({2'd2, 1'b1}),
        entry_t'({2'd1, 1'b1}),
        entry_t'({2'd0, 1'b1})
    };

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/lut_demux_match.sv
// Purpose     : compare a key against every table entry, pick the lowest-index hit.
// Latency     : combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   i_table    full routing table (entry i <-> channel i)
//   i_key      lookup key
//   o_hit_vec  per-entry match (enabled and key equal)
//   o_hit_any  at least one entry matched
//   o_hit_idx  lowest matching index; 0 when nothing matched
module lut_match
    import lut_demux_pkg::*;
(
    input  table_t             i_table,
    input  logic [KEY_LEN-1:0] i_key,
    output logic [NR_CH-1:0]   o_hit_vec,
    output logic               o_hit_any,
    output logic [IDX_W-1:0]   o_hit_idx
);

    always_comb begin
        o_hit_vec = '0;
        for (int i = 0; i < NR_CH; i++) begin
            o_hit_vec[i] = i_table[i].en && (i_table[i].key == i_key);
        end
    end

    assign o_hit_any = |o_hit_vec;

    // Scan from the top down so the last assignment, the lowest index,
    // wins when several entries carry the same key.
    always_comb begin
        o_hit_idx = '0;
        for (int i = NR_CH - 1; i >= 0; i--) begin
            if (o_hit_vec[i]) begin
                o_hit_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/lut_demux.sv
// Purpose     : route a keyed item to one of four single-entry output channels via a run-time table.
// Latency     : one cycle from accept to out_valid/out_data; miss pulse one cycle after a drop.
// Backpressure: in_ready low only when the target channel is full and not draining; misses never stall.
//
// Ports:
//   i_clk, i_rst_n                       clock, async active-low reset
//   i_cfg_we/idx/key/en                  table entry write (takes effect at the edge)
//   i_in_valid, o_in_ready               input handshake
//   i_in_key, i_in_data                  input item
//   o_out_valid, i_out_ready             per-channel output handshake
//   o_out_data                           channel i data at [DATA_LEN*i +: DATA_LEN]
//   o_miss, o_miss_cnt                   drop pulse and saturating drop count
module lut_demux
    import lut_demux_pkg::*;
(
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_cfg_we,
    input  logic [IDX_W-1:0]          i_cfg_idx,
    input  logic [KEY_LEN-1:0]        i_cfg_key,
    input  logic                      i_cfg_en,
    input  logic                      i_in_valid,
    output logic                      o_in_ready,
    input  logic [KEY_LEN-1:0]        i_in_key,
    input  logic [DATA_LEN-1:0]       i_in_data,
    output logic [NR_CH-1:0]          o_out_valid,
    input  logic [NR_CH-1:0]          i_out_ready,
    output logic [NR_CH*DATA_LEN-1:0] o_out_data,
    output logic                      o_miss,
    output logic [CNT_W-1:0]          o_miss_cnt
);

    table_t                    r_table;
    logic [NR_CH-1:0]          r_out_valid;
    logic [NR_CH*DATA_LEN-1:0] r_out_data;
    logic                      r_miss;
    logic [CNT_W-1:0]          r_miss_cnt;

    logic [NR_CH-1:0]          w_hit_vec;
    logic                      w_hit_any;
    logic [IDX_W-1:0]          w_hit_idx;
    logic                      w_tgt_busy;
    logic                      w_accept;
    logic                      w_drop;
    logic [NR_CH-1:0]          w_load;

    // Lookup always sees the registered table, so a same-cycle config
    // write only affects items from the next cycle on.
    lut_match u_match (
        .i_table   (r_table),
        .i_key     (i_in_key),
        .o_hit_vec (w_hit_vec),
        .o_hit_any (w_hit_any),
        .o_hit_idx (w_hit_idx)
    );

    // Target is blocked only if it holds an item its consumer is not taking
    // this cycle; a draining channel can be refilled with no bubble.
    // in_valid deliberately does not feed in_ready.
    assign w_tgt_busy = r_out_valid[w_hit_idx] && !i_out_ready[w_hit_idx];
    assign o_in_ready = w_hit_any ? !w_tgt_busy : 1'b1;

    assign w_accept = i_in_valid && o_in_ready;
    assign w_drop   = w_accept && !w_hit_any;

    always_comb begin
        w_load = '0;
        for (int i = 0; i < NR_CH; i++) begin
            w_load[i] = w_accept && w_hit_any && (w_hit_idx == IDX_W'(i));
        end
    end

    // Routing table
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_table <= TABLE_RST;
        end else if (i_cfg_we) begin
            r_table[i_cfg_idx].key <= i_cfg_key;
            r_table[i_cfg_idx].en  <= i_cfg_en;
        end
    end

    // Channel holding registers: a load beats a drain, so a channel that
    // drains and refills in the same cycle stays valid with new data.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_valid <= '0;
            r_out_data  <= '0;
        end else begin
            for (int i = 0; i < NR_CH; i++) begin
                if (w_load[i]) begin
                    r_out_valid[i]                     <= 1'b1;
                    r_out_data[DATA_LEN*i +: DATA_LEN] <= i_in_data;
                end else if (i_out_ready[i]) begin
                    r_out_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Drop reporting
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_miss     <= 1'b0;
            r_miss_cnt <= '0;
        end else begin
            r_miss <= w_drop;
            if (w_drop) begin
                r_miss_cnt <= sat_inc(r_miss_cnt);
            end
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_miss      = r_miss;
    assign o_miss_cnt  = r_miss_cnt;

endmodule

// File: tb/tb_lut_demux.sv
// Purpose     : directed stimulus with a queue-based scoreboard for lut_demux.
// Latency     : n/a.
// Backpressure: bench drives out_ready per scenario.
module tb_lut_demux;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_cfg_we;
    logic [1:0] i_cfg_idx;
    logic [1:0] i_cfg_key;
    logic       i_cfg_en;
    logic       i_in_valid;
    logic       o_in_ready;
    logic [1:0] i_in_key;
    logic [1:0] i_in_data;
    logic [3:0] o_out_valid;
    logic [3:0] i_out_ready;
    logic [7:0] o_out_data;
    logic       o_miss;
    logic [7:0] o_miss_cnt;

    lut_demux dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_cfg_we    (i_cfg_we),
        .i_cfg_idx   (i_cfg_idx),
        .i_cfg_key   (i_cfg_key),
        .i_cfg_en    (i_cfg_en),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_in_key    (i_in_key),
        .i_in_data   (i_in_data),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_out_data  (o_out_data),
        .o_miss      (o_miss),
        .o_miss_cnt  (o_miss_cnt)
    );

    always #5 i_clk = ~i_clk;

    int n_chk  = 0;
    int n_pass = 0;
    int exp_miss = 0;

    logic [1:0] exp_q [4][$];   // expected data per channel, in drain order
    int         miss_q [$];     // expected miss_cnt at each miss pulse

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    task automatic flag(input string name);
        n_chk++;
        $display("FAIL %s", name);
    endtask

    // Monitor: every output handshake or miss pulse pops one expectation.
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            for (int i = 0; i < 4; i++) begin
                if (o_out_valid[i] && i_out_ready[i]) begin
                    if (exp_q[i].size() == 0) flag($sformatf("unexpected item on ch%0d data %0h", i, o_out_data[2*i +: 2]));
                    else chk($sformatf("ch%0d data", i), 32'(o_out_data[2*i +: 2]), 32'(exp_q[i].pop_front()));
                end
            end
            if (o_miss) begin
                if (miss_q.size() == 0) flag("unexpected miss pulse");
                else chk("miss_cnt at miss", 32'(o_miss_cnt), 32'(miss_q.pop_front()));
            end
        end
    end

    // Called one time unit after a rising edge; returns at the same phase one cycle later.
    task automatic send(input logic [1:0] key, input logic [1:0] data,
                        input logic exp_rdy, input int exp_ch);
        i_in_valid = 1'b1;
        i_in_key   = key;
        i_in_data  = data;
        #1;
        chk($sformatf("in_ready key %0d", key), 32'(o_in_ready), 32'(exp_rdy));
        if (o_in_ready && exp_rdy) begin
            if (exp_ch < 0) begin
                exp_miss = (exp_miss == 255) ? 255 : exp_miss + 1;
                miss_q.push_back(exp_miss);
            end else begin
                exp_q[exp_ch].push_back(data);
            end
        end
        @(posedge i_clk); #1;
        i_in_valid = 1'b0;
    endtask

    task automatic cfg(input logic [1:0] idx, input logic [1:0] key, input logic en);
        i_cfg_we = 1'b1; i_cfg_idx = idx; i_cfg_key = key; i_cfg_en = en;
        @(posedge i_clk); #1;
        i_cfg_we = 1'b0;
    endtask

    task automatic drain();
        i_out_ready = 4'hF;
        repeat (2) @(posedge i_clk);
        #1;
        chk("out_valid after drain", 32'(o_out_valid), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        i_rst_n = 1'b0; i_cfg_we = 1'b0; i_cfg_idx = '0; i_cfg_key = '0; i_cfg_en = 1'b0;
        i_in_valid = 1'b0; i_in_key = '0; i_in_data = '0; i_out_ready = 4'h0;
        #22 i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        // Reset state
        chk("reset out_valid", 32'(o_out_valid), 32'h0);
        chk("reset out_data",  32'(o_out_data),  32'h0);
        chk("reset miss",      32'(o_miss),      32'h0);
        chk("reset miss_cnt",  32'(o_miss_cnt),  32'h0);
        chk("reset in_ready",  32'(o_in_ready),  32'h1);

        // Basic route and backpressure on a full channel
        send(2'd2, 2'd3, 1'b1, 2);
        chk("t1 out_valid", 32'(o_out_valid), 32'h4);
        chk("t1 data ch2",  32'(o_out_data[5:4]), 32'h3);
        send(2'd2, 2'd1, 1'b0, 2);
        chk("t1 blocked out_valid", 32'(o_out_valid), 32'h4);
        chk("t1 blocked data ch2",  32'(o_out_data[5:4]), 32'h3);
        drain();

        // Remap entry 1 to key 3, disable entry 3
        i_out_ready = 4'h0;
        cfg(2'd1, 2'd3, 1'b1);
        cfg(2'd3, 2'd3, 1'b0);
        send(2'd3, 2'd1, 1'b1, 1);
        chk("t2 out_valid", 32'(o_out_valid), 32'h2);
        chk("t2 data ch1",  32'(o_out_data[3:2]), 32'h1);
        send(2'd1, 2'd0, 1'b1, -1);   // key 1 no longer mapped
        drain();
        cfg(2'd1, 2'd1, 1'b1);
        cfg(2'd3, 2'd3, 1'b1);

        // Drain and refill channel 0 in the same cycle
        i_out_ready = 4'h0;
        send(2'd0, 2'd1, 1'b1, 0);
        i_out_ready = 4'h1;
        send(2'd0, 2'd2, 1'b1, 0);
        chk("t3 out_valid", 32'(o_out_valid), 32'h1);
        chk("t3 data ch0",  32'(o_out_data[1:0]), 32'h2);
        drain();

        // Config write in the same cycle as a lookup uses the old table
        i_cfg_we = 1'b1; i_cfg_idx = 2'd0; i_cfg_key = 2'd1; i_cfg_en = 1'b1;
        send(2'd0, 2'd3, 1'b1, 0);
        i_cfg_we = 1'b0;
        send(2'd0, 2'd0, 1'b1, -1);   // key 0 now unmapped
        send(2'd1, 2'd2, 1'b1, 0);    // entries 0 and 1 both key 1: channel 0 wins
        drain();

        // All entries disabled: every item is dropped, counter saturates
        for (int i = 0; i < 4; i++) cfg(2'(i), 2'(i), 1'b0);
        for (int n = 0; n < 300; n++) send(2'(n), 2'(n >> 2), 1'b1, -1);
        @(posedge i_clk); #1;
        chk("t5 miss_cnt saturated", 32'(o_miss_cnt), 32'd255);
        chk("t5 out_valid", 32'(o_out_valid), 32'h0);
        chk("t5 miss ended", 32'(o_miss), 32'h0);

        // Reset mid-operation
        i_rst_n = 1'b0; #3; i_rst_n = 1'b1;
        exp_miss = 0;
        @(posedge i_clk); #1;
        cfg(2'd0, 2'd0, 1'b0);
        for (int n = 0; n < 5; n++) send(2'd0, 2'd1, 1'b1, -1);
        cfg(2'd0, 2'd0, 1'b1);
        i_out_ready = 4'h0;
        for (int k = 0; k < 4; k++) send(2'(k), 2'(3 - k), 1'b1, k);
        chk("t6 full out_valid", 32'(o_out_valid), 32'hF);
        chk("t6 miss_cnt", 32'(o_miss_cnt), 32'd5);
        #2 i_rst_n = 1'b0;
        #1;
        chk("t6 reset out_valid", 32'(o_out_valid), 32'h0);
        chk("t6 reset miss_cnt",  32'(o_miss_cnt),  32'h0);
        chk("t6 reset out_data",  32'(o_out_data),  32'h0);
        for (int i = 0; i < 4; i++) exp_q[i].delete();
        miss_q.delete();
        exp_miss = 0;
        @(negedge i_clk); i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        send(2'd3, 2'd2, 1'b1, 3);
        chk("t6 identity key3", 32'(o_out_valid), 32'h8);
        send(2'd1, 2'd1, 1'b1, 1);
        chk("t6 identity key1", 32'(o_out_valid), 32'hA);
        send(2'd0, 2'd3, 1'b1, 0);
        chk("t6 identity key0", 32'(o_out_valid), 32'hB);
        send(2'd2, 2'd0, 1'b1, 2);
        chk("t6 identity key2", 32'(o_out_valid), 32'hF);
        drain();

        repeat (3) @(posedge i_clk);
        #1;
        for (int i = 0; i < 4; i++) chk($sformatf("ch%0d queue empty", i), 32'(exp_q[i].size()), 32'd0);
        chk("miss queue empty", 32'(miss_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
